// File: rtl/err_eval_ctrl.sv
// Error-evaluation sequencer: drives LFSR operands to an approximate adder
// and gathers error stats. Define ERR_EVAL_EXHAUSTIVE_EN for counter operands.
module err_eval_ctrl #(
   parameter int W       = 16,
   parameter int CNT_W   = 32,
   parameter int ACC_W   = 48,
   parameter int DUT_LAT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_samples,
   input  logic [31:0]      seed,
`ifdef ERR_EVAL_EXHAUSTIVE_EN
   input  logic             exhaustive,
`endif
   output logic [W-1:0]     op_a,
   output logic [W-1:0]     op_b,
   output logic             op_valid,
   input  logic [W:0]       approx_sum,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [W:0]       max_err,
   output logic [ACC_W-1:0] sum_abs_err
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [31:0] TAPS = 32'h8020_0003;
   localparam int SW = ((ACC_W > W + 1) ? ACC_W : W + 1) + 1;
   localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

   state_t           r_state;
   logic [31:0]      r_lfsr;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_issued;
   logic [W-1:0]     r_op_a;
   logic [W-1:0]     r_op_b;
   logic             r_op_valid;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] r_err_count;
   logic [W:0]       r_max_err;
   logic [W:0]       r_err;
   logic             r_err_v;
   logic [ACC_W-1:0] r_sum_abs;

   logic [31:0]      w_seed_eff;
   logic [31:0]      w_src;
   logic [W-1:0]     w_nxt_a;
   logic [W-1:0]     w_nxt_b;
   logic [W:0]       w_exact;
   logic [W:0]       w_due_sum;
   logic [W:0]       w_abs;
   logic             w_due_v;
   logic             w_inflight;
   logic [SW-1:0]    w_sum_ext;

   function automatic logic [31:0] f_lfsr(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   // First pair comes straight from the (non-zero) seed
   assign w_seed_eff = (seed == 32'd0) ? 32'd1 : seed;
   assign w_src      = (r_state == S_IDLE) ? w_seed_eff : r_lfsr;

`ifdef ERR_EVAL_EXHAUSTIVE_EN
   localparam int CW = 2 * W;
   logic          r_exh;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt;
   logic          w_exh;
   logic          w_issue;

   assign w_exh   = (r_state == S_IDLE) ? exhaustive : r_exh;
   assign w_cnt   = (r_state == S_IDLE) ? '0 : r_cnt;
   assign w_nxt_a = w_exh ? w_cnt[W-1:0]    : w_src[W-1:0];
   assign w_nxt_b = w_exh ? w_cnt[CW-1:W]   : w_src[W+15:16];
   assign w_issue = !abort &&
      ((r_state == S_IDLE && start && num_samples != '0) ||
       (r_state == S_RUN && r_issued != r_num));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exh <= 1'b0;
         r_cnt <= '0;
      end else begin
         if (!abort && r_state == S_IDLE && start)
            r_exh <= exhaustive;
         if (w_issue)
            r_cnt <= w_cnt + CW'(1);
      end
   end
`else
   assign w_nxt_a = w_src[W-1:0];
   assign w_nxt_b = w_src[W+15:16];
`endif

   assign w_exact = {1'b0, r_op_a} + {1'b0, r_op_b};

   generate
      if (DUT_LAT == 0) begin : g_comb
         assign w_due_sum  = w_exact;
         assign w_due_v    = r_op_valid;
         assign w_inflight = r_op_valid;
      end else begin : g_pipe
         logic [W:0]         r_dly_sum [DUT_LAT];
         logic [DUT_LAT-1:0] r_dly_v;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_dly_v <= '0;
               for (int i = 0; i < DUT_LAT; i++)
                  r_dly_sum[i] <= '0;
            end else begin
               r_dly_sum[0] <= w_exact;
               r_dly_v[0]   <= r_op_valid && !abort;
               for (int i = 1; i < DUT_LAT; i++) begin
                  r_dly_sum[i] <= r_dly_sum[i-1];
                  r_dly_v[i]   <= r_dly_v[i-1] && !abort;
               end
            end
         end

         assign w_due_sum  = r_dly_sum[DUT_LAT-1];
         assign w_due_v    = r_dly_v[DUT_LAT-1];
         assign w_inflight = r_op_valid || (|r_dly_v);
      end
   endgenerate

   assign w_abs = (w_due_sum >= approx_sum) ? w_due_sum - approx_sum
                                            : approx_sum - w_due_sum;
   assign w_sum_ext = SW'(r_sum_abs) + SW'(r_err);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_lfsr      <= 32'd1;
         r_num       <= '0;
         r_issued    <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_op_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err_count <= '0;
         r_max_err   <= '0;
         r_err       <= '0;
         r_err_v     <= 1'b0;
         r_sum_abs   <= '0;
      end else begin
         r_done  <= 1'b0;
         r_err_v <= w_due_v && !abort;
         if (w_due_v)
            r_err <= w_abs;
         // Abort drops the sample that would have landed on this edge
         if (r_err_v && !abort) begin
            if (r_err != '0 && r_err_count != '1)
               r_err_count <= r_err_count + CNT_W'(1);
            if (r_err > r_max_err)
               r_max_err <= r_err;
            r_sum_abs <= (w_sum_ext > ACC_MAX) ? '1 : w_sum_ext[ACC_W-1:0];
         end
         if (abort) begin
            r_state    <= S_IDLE;
            r_op_valid <= 1'b0;
            r_busy     <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_num       <= num_samples;
                     r_err_count <= '0;
                     r_max_err   <= '0;
                     r_sum_abs   <= '0;
                     if (num_samples == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_op_a     <= w_nxt_a;
                        r_op_b     <= w_nxt_b;
                        r_op_valid <= 1'b1;
                        r_issued   <= CNT_W'(1);
                        r_lfsr     <= f_lfsr(w_src);
                     end
                  end
               end
               S_RUN: begin
                  if (r_issued == r_num) begin
                     r_state    <= S_DRAIN;
                     r_op_valid <= 1'b0;
                  end else begin
                     r_op_a   <= w_nxt_a;
                     r_op_b   <= w_nxt_b;
                     r_issued <= r_issued + CNT_W'(1);
                     r_lfsr   <= f_lfsr(w_src);
                  end
               end
               S_DRAIN: begin
                  if (!w_inflight) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               S_DONE: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign op_a        = r_op_a;
   assign op_b        = r_op_b;
   assign op_valid    = r_op_valid;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err_count   = r_err_count;
   assign max_err     = r_max_err;
   assign sum_abs_err = r_sum_abs;
endmodule

// File: tb/tb_err_eval_ctrl.sv
// Randomized bench for err_eval_ctrl: three instances (latency 0, latency 3,
// narrow accumulator) checked against a sequence-level reference model.
module tb_err_eval_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] num = '0;
   logic [31:0] seed = '0;
   bit          exh = 1'b0;
   int          mode = 0;

   logic [15:0] opa0, opb0, opa3, opb3, opas, opbs;
   logic        v0, v3, vs, busy0, busy3, busys, done0, done3, dones;
   logic [16:0] ap0, ap3, aps, me0, me3, mes, p1, p2, p3;
   logic [31:0] ec0, ec3, ecs;
   logic [47:0] sa0, sa3;
   logic [19:0] sas;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int nd0, nd3, nds, last0, last3, dcyc0, dcyc3, st_cyc, nvs;
   bit bz0, bz3, bzs;
   logic [31:0] q0[$], q3[$], exp_ops[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural approximate adders: 0 exact, 1 zero, 2 LSB cleared, 3 LOA
   function automatic logic [16:0] fadd(input logic [15:0] a,
                                        input logic [15:0] b, input int m);
      logic [16:0] s, hi;
      s  = {1'b0, a} + {1'b0, b};
      hi = 17'(a[15:4]) + 17'(b[15:4]);
      case (m)
         1:       return '0;
         2:       return s & ~17'd1;
         3:       return (hi << 4) | 17'(a[3:0] | b[3:0]);
         default: return s;
      endcase
   endfunction

   assign ap0 = fadd(opa0, opb0, mode);
   assign aps = fadd(opas, opbs, mode);
   always @(posedge clk) begin
      p1 <= fadd(opa3, opb3, mode);
      p2 <= p1;
      p3 <= p2;
   end
   assign ap3 = p3;

   err_eval_ctrl #(.DUT_LAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_samples(num), .seed(seed),
`ifdef ERR_EVAL_EXHAUSTIVE_EN
      .exhaustive(exh),
`endif
      .op_a(opa0), .op_b(opb0), .op_valid(v0), .approx_sum(ap0),
      .busy(busy0), .done(done0), .err_count(ec0), .max_err(me0),
      .sum_abs_err(sa0));

   err_eval_ctrl #(.DUT_LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_samples(num), .seed(seed),
`ifdef ERR_EVAL_EXHAUSTIVE_EN
      .exhaustive(exh),
`endif
      .op_a(opa3), .op_b(opb3), .op_valid(v3), .approx_sum(ap3),
      .busy(busy3), .done(done3), .err_count(ec3), .max_err(me3),
      .sum_abs_err(sa3));

   err_eval_ctrl #(.DUT_LAT(0), .ACC_W(20)) us (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_samples(num), .seed(seed),
`ifdef ERR_EVAL_EXHAUSTIVE_EN
      .exhaustive(exh),
`endif
      .op_a(opas), .op_b(opbs), .op_valid(vs), .approx_sum(aps),
      .busy(busys), .done(dones), .err_count(ecs), .max_err(mes),
      .sum_abs_err(sas));

   always @(negedge clk) begin
      if (v0) begin q0.push_back({opb0, opa0}); last0 = cyc; end
      if (v3) begin q3.push_back({opb3, opa3}); last3 = cyc; end
      if (vs) nvs++;
      if (done0) begin nd0++; dcyc0 = cyc; end
      if (done3) begin nd3++; dcyc3 = cyc; end
      if (dones) nds++;
      if (busy0) bz0 = 1'b1;
      if (busy3) bz3 = 1'b1;
      if (busys) bzs = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected stats for the first n pairs of a run, accumulator width accw
   task automatic model(input int n, input logic [31:0] sd, input int accw,
                        output longint ec, output longint me,
                        output longint sa);
      logic [31:0] s, pr;
      int ex_, apx, e;
      longint mx;
      s  = (sd == 32'd0) ? 32'd1 : sd;
      ec = 0; me = 0; sa = 0;
      mx = (64'sd1 <<< accw) - 1;
      exp_ops.delete();
      for (int i = 0; i < n; i++) begin
         pr = exh ? 32'(i) : s;
         exp_ops.push_back(pr);
         ex_ = int'(pr[15:0]) + int'(pr[31:16]);
         apx = int'(fadd(pr[15:0], pr[31:16], mode));
         e   = (ex_ > apx) ? ex_ - apx : apx - ex_;
         if (e != 0) ec++;
         if (e > me) me = e;
         sa = sa + e;
         if (sa > mx) sa = mx;
         s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
      end
   endtask

   task automatic clr_mon();
      q0.delete(); q3.delete();
      nd0 = 0; nd3 = 0; nds = 0; nvs = 0;
      bz0 = 0; bz3 = 0; bzs = 0;
      last0 = 0; last3 = 0; dcyc0 = 0; dcyc3 = 0;
   endtask

   task automatic run_chk(input int n, input logic [31:0] sd, input int m,
                          input bit ex);
      longint ec, me, sa;
      int mm0, mm3;
      @(negedge clk);
      num = 32'(n); seed = sd; mode = m; exh = ex;
      clr_mon();
      st_cyc = cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < n + 40; k++) begin
         @(negedge clk); #1;
         if (nd0 > 0 && nd3 > 0 && nds > 0) break;
      end
      repeat (3) @(negedge clk);
      #1;
      model(n, sd, 48, ec, me, sa);
      mm0 = 0; mm3 = 0;
      foreach (exp_ops[i]) begin
         if (i >= q0.size() || q0[i] !== exp_ops[i]) mm0++;
         if (i >= q3.size() || q3[i] !== exp_ops[i]) mm3++;
      end
      chk("done0_cnt", 64'(nd0), 64'd1);
      chk("done3_cnt", 64'(nd3), 64'd1);
      chk("nops0", 64'(q0.size()), 64'(n));
      chk("nops3", 64'(q3.size()), 64'(n));
      chk("opseq0", 64'(mm0), 64'd0);
      chk("opseq3", 64'(mm3), 64'd0);
      chk("err_count0", 64'(ec0), 64'(ec));
      chk("max_err0", 64'(me0), 64'(me));
      chk("sum_abs0", 64'(sa0), 64'(sa));
      chk("err_count3", 64'(ec3), 64'(ec));
      chk("max_err3", 64'(me3), 64'(me));
      chk("sum_abs3", 64'(sa3), 64'(sa));
      if (n > 0) begin
         chk("done_lat0", 64'(dcyc0 - last0), 64'd2);
         chk("done_lat3", 64'(dcyc3 - last3), 64'd5);
      end else begin
         chk("done_n0", 64'(dcyc0 - st_cyc), 64'd1);
         chk("busy_n0", 64'(bz0 | bz3 | bzs), 64'd0);
      end
      model(n, sd, 20, ec, me, sa);
      chk("nops_s", 64'(nvs), 64'(n));
      chk("done_s_cnt", 64'(nds), 64'd1);
      chk("err_count_s", 64'(ecs), 64'(ec));
      chk("max_err_s", 64'(mes), 64'(me));
      chk("sum_abs_sat", 64'(sas), 64'(sa));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint ec, me, sa;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(v0 | v3 | vs), 64'd0);
      chk("rst_busy", 64'(busy0 | busy3), 64'd0);
      chk("rst_done", 64'(done0 | done3), 64'd0);
      chk("rst_ops", 64'({opb0, opa0}), 64'd0);
      chk("rst_err", 64'(ec0) + 64'(me0) + 64'(sa0), 64'd0);
      rst_n = 1'b1;

      run_chk(1000, 32'h1234_ABCD, 0, 1'b0);
      run_chk(1, 32'd1, 1, 1'b0);
      chk("first_pair", 64'(q0[0]), 64'h0000_0001);
      chk("one_err_sum", 64'(sa0), 64'd1);
      run_chk(0, 32'h0BAD_F00D, 1, 1'b0);
      run_chk(16, $urandom, 2, 1'b0);
      chk("lsb_max", 64'(me3), 64'd1);
      run_chk(40, $urandom, 1, 1'b0);
      chk("acc_saturated", 64'(sas), 64'hF_FFFF);
      run_chk(5, 32'd0, 1, 1'b0);
      for (int r = 0; r < 5; r++)
         run_chk($urandom_range(60, 1), $urandom, $urandom_range(3, 0), 1'b0);

      // Abort in the 5th RUN cycle, with a stray start during RUN
      @(negedge clk);
      num = 32'd100; seed = 32'h5A5A_0F0F; mode = 1; exh = 1'b0;
      clr_mon();
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      #1;
      chk("abort_valid", 64'(v0 | v3 | vs), 64'd0);
      chk("abort_busy", 64'(busy0 | busy3 | busys), 64'd0);
      repeat (6) @(negedge clk);
      #1;
      chk("abort_nodone", 64'(nd0 + nd3 + nds), 64'd0);
      model(3, 32'h5A5A_0F0F, 48, ec, me, sa);
      chk("abort_ec0", 64'(ec0), 64'(ec));
      chk("abort_me0", 64'(me0), 64'(me));
      chk("abort_sa0", 64'(sa0), 64'(sa));
      chk("abort_ec3", 64'(ec3), 64'd0);
      run_chk(8, $urandom, 0, 1'b0);

`ifdef ERR_EVAL_EXHAUSTIVE_EN
      run_chk(4, 32'h0000_DEAD, 1, 1'b1);
      chk("exh_ec", 64'(ec0), 64'd3);
      chk("exh_me", 64'(me0), 64'd3);
      chk("exh_sa", 64'(sa0), 64'd6);
      exh = 1'b0;
`endif

      // Asynchronous reset in the middle of a run
      @(negedge clk);
      num = 32'd50; seed = $urandom; mode = 1;
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(v0 | v3 | vs), 64'd0);
      chk("midrst_busy", 64'(busy0 | busy3 | busys), 64'd0);
      chk("midrst_err", 64'(ec0) + 64'(sa0) + 64'(me0), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_chk(12, $urandom, 3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/err_eval_ctrl.md
Name: err_eval_ctrl

Overview:
Self-contained error-evaluation sequencer for a combinational or pipelined approximate adder under test (W-bit operands, W+1-bit sum).
- Generates operand pairs from a 32-bit LFSR and drives them to the adder, one pair per cycle.
- Computes the exact sum internally and compares it against the adder's returned sum.
- Accumulates error statistics: error count, max error distance, sum of absolute errors.
- Sits beside the approximate adder in the evaluation harness; start/done handshake to the host.

Parameters:
W, 16, operand width; adder sum is W+1 bits
CNT_W, 32, width of sample counters and err_count
ACC_W, 48, width of sum_abs_err accumulator
DUT_LAT, 0, adder latency in cycles (0..4); 0 = purely combinational

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE, results frozen
num_samples  in  CNT_W  operand pairs to issue; latched on start
seed  in  32  LFSR seed; latched on start; 0 is replaced by 1
op_a  out  W  operand A to adder (registered)
op_b  out  W  operand B to adder (registered)
op_valid  out  1  op_a/op_b carry a live sample this cycle
approx_sum  in  W+1  adder result
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when a run completes
err_count  out  CNT_W  samples with approx_sum != exact sum (saturating)
max_err  out  W+1  max |exact - approx| seen
sum_abs_err  out  ACC_W  sum of |exact - approx| (saturating at all-ones)

Behaviour:
- Reset: FSM=IDLE; op_a, op_b, op_valid, busy, done = 0; err_count, max_err, sum_abs_err = 0; LFSR = 1.
- Clock/reset: one clock, clk; reset is asynchronous active-low, rst_n.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches num_samples and seed, and clears all result registers.
  - num_samples=0 -> DONE; otherwise -> RUN.
- RUN:
  - Each cycle: op_a = lfsr[W-1:0], op_b = lfsr[W+15:16] (W=16: lfsr[31:16]); op_valid=1.
  - LFSR advances; issued counter increments.
  - After num_samples pairs are issued -> DRAIN.
- LFSR: Galois, 32-bit, taps mask 0x80200003, shift right; the first pair uses the seed value itself.
- Compare pipeline: exact = op_a + op_b (W+1 bits), delayed DUT_LAT cycles alongside a valid token.
  - A pair issued in cycle t has approx_sum sampled at the edge ending cycle t+DUT_LAT.
  - Accumulators update at the next edge (end of cycle t+DUT_LAT+1).
- Error: err = |exact - approx_sum|, unsigned W+1 bits.
  - err != 0 increments err_count.
  - max_err = max(max_err, err).
  - sum_abs_err += err.
  - err_count and sum_abs_err saturate; they do not wrap.
- DRAIN: waits until no valid token is in flight, then -> DONE. For last issue in cycle t_last, done is high in cycle t_last+DUT_LAT+2.
- DONE: done=1 for exactly one cycle -> IDLE. Results hold until the next accepted start.
- start while busy or in DONE: ignored.
- abort: takes priority over start and over all transitions.
  - Next cycle: FSM=IDLE, op_valid=0, in-flight tokens discarded.
  - Results hold their partial values; done is not pulsed.
- approx_sum is ignored whenever no valid token is due.
- Reset mid-run: immediate return to reset values regardless of state.

Optional Feature:
Macro ERR_EVAL_EXHAUSTIVE_EN.
- Defined: adds input port exhaustive (1 bit), latched on start.
  - exhaustive=1: operands come from a 2W-bit up-counter starting at 0, {op_b,op_a} = count; seed is ignored; num_samples still bounds the run.
  - If num_samples exceeds 2^(2W), the counter wraps to 0.
  - exhaustive=0: LFSR mode as above.
- Not defined: no exhaustive port; LFSR mode only; no counter logic present.

Test Plan:
- Exact adder model (approx_sum = op_a+op_b), seed=0x1234ABCD, num_samples=1000, DUT_LAT=0 -> done pulses once; err_count=0, max_err=0, sum_abs_err=0.
- approx_sum tied to 0, seed=1, num_samples=1 -> op_a=0x0001, op_b=0x0000; err_count=1, max_err=1, sum_abs_err=1; done 2 cycles after the issue cycle.
- num_samples=0 -> done one cycle after start; busy never asserts; all results 0.
- DUT_LAT=3, exact model with approx LSB forced to 0, num_samples=16 -> err_count = count of odd exact sums; max_err=1; done in cycle t_last+5.
- abort asserted in the 5th RUN cycle with num_samples=100 -> IDLE next cycle; no done; start during RUN is ignored; a fresh start clears results.
- ERR_EVAL_EXHAUSTIVE_EN, exhaustive=1, num_samples=4, approx_sum=0 -> operands (0,0), (1,0), (2,0), (3,0); err_count=3, max_err=3, sum_abs_err=6.
